// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared between the core and its memory-side blocks.
//   - mem_rw operation codes driven by the core on its data-memory port
//   - state encoding of the data-memory responder FSM
//   - latched request record held by the responder between accept and response
package riscv_pkg;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'b00,
        RSP_WAIT = 2'b01,
        RSP_RESP = 2'b10
    } rsp_state_t;

    // Request fields that are independent of the address width.
    typedef struct packed {
        logic [1:0]  op;
        logic        err;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port synchronous RAM, DEPTH_WORDS x 32 bits.
//   clk    in   clock, rising edge
//   en     in   access enable; reads and writes happen only when set
//   we     in   per-byte write enables (bit i -> wdata[8i+7:8i])
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data (value before any same-cycle write)
// Contents are not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory interface.
// Accepts one load/store at a time over a valid/ready request handshake, waits
// LATENCY cycles, then presents the result over a valid/ready response handshake.
//   clk, rst              clock and synchronous active-high reset
//   req_valid, req_ready  request handshake (ready only in IDLE)
//   mem_rw, addr          operation code and byte address
//   wdata, wmask          store data and byte enables
//   rsp_valid, rsp_ready  response handshake (response held until consumed)
//   rdata, rsp_err        load data (0 for stores/errors) and reject flag
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        mem_rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rdata,
    output logic              rsp_err
);

    localparam int              IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]      LAT4  = 4'(LATENCY);

    rsp_state_t       state;
    logic [3:0]       cnt;
    mem_req_t         req_q;
    logic [IDX_W-1:0] idx_q;
    logic             rd_sel;   // response carries array read data

    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx_in;
    logic              in_err;
    logic              accept;
    logic              go_resp;
    mem_req_t          cur;
    logic [IDX_W-1:0]  cur_idx;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;

    // Offset is computed in ADDR_W bits; addresses below BASE_ADDR wrap high
    // and are also caught explicitly, so nothing wraps back into range.
    assign off    = addr - BASE_ADDR;
    assign idx_in = off[IDX_W+1:2];
    assign in_err = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) ||
                    ({1'b0, off} >= SPAN) || (mem_rw == MEM_RSVD);
    assign accept = (state == RSP_IDLE) && req_valid && (mem_rw != MEM_IDLE);

    // Edge on which the FSM enters RESP: the array is accessed exactly then.
    assign go_resp = (LATENCY == 0) ? accept : ((state == RSP_WAIT) && (cnt == 4'd1));

    // With zero latency the access uses the live request, otherwise the latch.
    always_comb begin
        if (state == RSP_IDLE) begin
            cur     = '{op: mem_rw, err: in_err, wmask: wmask, wdata: wdata};
            cur_idx = idx_in;
        end else begin
            cur     = req_q;
            cur_idx = idx_q;
        end
    end

    // rst gates the enable so a reset on the commit edge drops the write.
    assign ram_en = go_resp && !cur.err && !rst;
    assign ram_we = (cur.op == MEM_WRITE) ? cur.wmask : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_idx),
        .wdata (cur.wdata),
        .rdata (ram_q)
    );

    // The array output only changes on an enabled access, which happens on
    // entry to RESP, so it stays stable for the whole response.
    assign rdata = rd_sel ? ram_q : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RSP_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel    <= 1'b0;
            cnt       <= '0;
            req_q     <= '0;
            idx_q     <= '0;
        end else begin
            case (state)
                RSP_IDLE: begin
                    if (accept) begin
                        req_q     <= cur;
                        idx_q     <= idx_in;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state     <= RSP_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= in_err;
                            rd_sel    <= (mem_rw == MEM_READ) && !in_err;
                        end else begin
                            state <= RSP_WAIT;
                            cnt   <= LAT4;
                        end
                    end
                end
                RSP_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RSP_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= req_q.err;
                        rd_sel    <= (req_q.op == MEM_READ) && !req_q.err;
                    end
                end
                RSP_RESP: begin
                    if (rsp_ready) begin
                        state     <= RSP_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rd_sel    <= 1'b0;
                    end
                end
                default: begin
                    state     <= RSP_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rd_sel    <= 1'b0;
                end
            endcase
        end
    end

endmodule
